word_packer: RTL and testbench

WORD_PACKER -- requirements
Module: word_packer

---
 rtl/word_packer.sv | 130 +++++++++++++
 tb/tb_word_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer.sv
// Byte-to-word packer: collects big-endian bytes into 32-bit words and supports flushing a partial word.
// With WORD_PACKER_COUNT_EN defined, a word_count output counts words transferred out.
module word_packer #(
  parameter int count_width = 32
) (
  input  logic                   clk,
  input  logic                   r,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_bytes,
`ifdef WORD_PACKER_COUNT_EN
  output logic [count_width-1:0] word_count,
`endif
  output logic [1:0]             lane_dbg
);

  typedef enum logic [1:0] {
    L0 = 2'd0,
    L1 = 2'd1,
    L2 = 2'd2,
    L3 = 2'd3
  } lane_e;

  lane_e       lane_q;
  lane_e       lane_d;
  logic [23:0] staging_q;
  logic [23:0] staging_d;
  logic [31:0] out_data_q;
  logic [1:0]  out_bytes_q;
  logic        out_valid_q;

  logic slot_free;
  logic byte_xfer;
  logic out_xfer;
  logic word_done;
  logic flush_take;

  // Handshake: a byte moves when in_valid & in_ready, a word moves when
  // out_valid & out_ready. in_ready is combinational so there is no bubble.
  always_comb begin
    slot_free  = ~out_valid_q | out_ready;
    in_ready   = ~r & ~(flush & ~slot_free) & ((lane_q != L3) | slot_free);
    byte_xfer  = in_valid & in_ready;
    out_xfer   = out_valid_q & out_ready;
    lane_d     = lane_q;
    staging_d  = staging_q;
    word_done  = 1'b0;
    if (byte_xfer) begin
      case (lane_q)
        L0: begin
          staging_d[23:16] = in_data;
          lane_d           = L1;
        end
        L1: begin
          staging_d[15:8] = in_data;
          lane_d          = L2;
        end
        L2: begin
          staging_d[7:0] = in_data;
          lane_d         = L3;
        end
        default: begin
          word_done = 1'b1;
          lane_d    = L0;
          staging_d = '0;
        end
      endcase
    end
    // Flush looks at the lane after this cycle's byte, so a byte that
    // completes the word turns the flush into a no-op.
    flush_take = flush & slot_free & (lane_d != L0);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      lane_q      <= L0;
      staging_q   <= '0;
      out_data_q  <= '0;
      out_bytes_q <= 2'b00;
      out_valid_q <= 1'b0;
    end else if (word_done) begin
      out_data_q  <= {staging_q, in_data};
      out_bytes_q <= 2'b00;
      out_valid_q <= 1'b1;
      lane_q      <= L0;
      staging_q   <= '0;
    end else if (flush_take) begin
      // Filled lane count equals the lane index after the byte.
      out_data_q  <= {staging_d, 8'h00};
      out_bytes_q <= lane_d;
      out_valid_q <= 1'b1;
      lane_q      <= L0;
      staging_q   <= '0;
    end else begin
      if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
      lane_q    <= lane_d;
      staging_q <= staging_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_valid = out_valid_q;
  assign lane_dbg  = lane_q;

`ifdef WORD_PACKER_COUNT_EN
  logic [count_width-1:0] word_count_q;

  always_ff @(posedge clk) begin
    if (r) begin
      word_count_q <= '0;
    end else if (out_xfer) begin
      word_count_q <= word_count_q + 1'b1;
    end
  end

  assign word_count = word_count_q;
`else
  logic [count_width-1:0] unused_count;
  assign unused_count = '0;
`endif

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: vector table plus hand sequences, words checked through an expected queue.
// Define WORD_PACKER_COUNT_EN to also exercise the word counter.
module tb_word_packer;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        r;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_bytes;
  logic [1:0]  lane_dbg;
`ifdef WORD_PACKER_COUNT_EN
  logic [CW-1:0] word_count;
`endif

  always #5 clk = ~clk;

  word_packer #(.count_width(CW)) dut (
    .clk       (clk),
    .r         (r),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bytes (out_bytes),
`ifdef WORD_PACKER_COUNT_EN
    .word_count(word_count),
`endif
    .lane_dbg  (lane_dbg)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        fl;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_lane;
    logic        push;
    logic [31:0] exp_word;
    logic [1:0]  exp_bytes;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic rr, input logic v, input logic [7:0] d,
                              input logic fl, input logic ordy, input logic rdy,
                              input logic ov, input logic [1:0] lane, input logic push,
                              input logic [31:0] word, input logic [1:0] bytes);
    vec_t x;
    x.r = rr; x.v = v; x.d = d; x.fl = fl; x.ordy = ordy;
    x.exp_rdy = rdy; x.exp_ov = ov; x.exp_lane = lane;
    x.push = push; x.exp_word = word; x.exp_bytes = bytes;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input string tag);
    r         = x.r;
    in_valid  = x.v;
    in_data   = x.d;
    flush     = x.fl;
    out_ready = x.ordy;
    if (x.push) exp_q.push_back({x.exp_word, x.exp_bytes});
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, x.exp_rdy});
    check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, x.exp_ov});
    check({tag, "_lane"}, {30'd0, lane_dbg}, {30'd0, x.exp_lane});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output transfer must match the head of the queue.
  always @(negedge clk) begin
    logic [33:0] e;
    if (r === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h/%0d expected none", out_data, out_bytes);
      end else begin
        e = exp_q.pop_front();
        check("word_data", out_data, e[33:2]);
        check("word_bytes", {30'd0, out_bytes}, {30'd0, e[1:0]});
      end
    end
  end

  initial begin
    logic [7:0]  b [4];
    logic [31:0] w;
    r = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and first cycle after reset
    apply(mk(1, 1, 8'h55, 0, 1, 0, 0, 0, 0, 0, 0), "rst");
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_bytes", {30'd0, out_bytes}, 32'h0);
`ifdef WORD_PACKER_COUNT_EN
    check("rst_word_count", {28'd0, word_count}, 32'h0);
`endif

    // DEADBEEF with one-cycle output latency
    vecs.push_back(mk(0, 1, 8'hDE, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hAD, 0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hBE, 0, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hEF, 0, 1, 1, 0, 3, 1, 32'hDEADBEEF, 2'd0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0));
    // 12 back-to-back bytes, in_ready never low
    for (int i = 0; i < 12; i++) begin
      w = {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)};
      vecs.push_back(mk(0, 1, 8'(i), 0, 1, 1, (i == 4 || i == 8), 2'(i % 4),
                        (i % 4 == 3), w, 2'd0));
    end
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0));
    // Two-byte flush, then flush in L0 is a no-op
    vecs.push_back(mk(0, 1, 8'hAA, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hBB, 0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 2, 1, 32'hAABB0000, 2'd2));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0));
    // Flush with the completing byte gives a normal full word
    vecs.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h03, 0, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h04, 1, 1, 1, 0, 3, 1, 32'h01020304, 2'd0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0));
    // Flush together with a byte in L1 includes that byte
    vecs.push_back(mk(0, 1, 8'h05, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h06, 1, 1, 1, 0, 1, 1, 32'h05060000, 2'd2));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0));
    // Three-byte flush
    vecs.push_back(mk(0, 1, 8'h07, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h08, 0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h09, 0, 1, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 3, 1, 32'h07080900, 2'd3));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Backpressure: three bytes accepted, L3 stalls, output held
    apply(mk(0, 1, 8'hA0, 0, 0, 1, 0, 0, 0, 0, 0), "bp0");
    apply(mk(0, 1, 8'hA1, 0, 0, 1, 0, 1, 0, 0, 0), "bp1");
    apply(mk(0, 1, 8'hA2, 0, 0, 1, 0, 2, 0, 0, 0), "bp2");
    apply(mk(0, 1, 8'hA3, 0, 0, 1, 0, 3, 1, 32'hA0A1A2A3, 2'd0), "bp3");
    apply(mk(0, 1, 8'hB0, 0, 0, 1, 1, 0, 0, 0, 0), "bp4");
    apply(mk(0, 1, 8'hB1, 0, 0, 1, 1, 1, 0, 0, 0), "bp5");
    apply(mk(0, 1, 8'hB2, 0, 0, 1, 1, 2, 0, 0, 0), "bp6");
    apply(mk(0, 1, 8'hB3, 0, 0, 0, 1, 3, 0, 0, 0), "bp7");
    apply(mk(0, 1, 8'hB3, 0, 0, 0, 1, 3, 0, 0, 0), "bp8");
    check("bp_hold_data", out_data, 32'hA0A1A2A3);
    check("bp_hold_bytes", {30'd0, out_bytes}, 32'h0);
    apply(mk(0, 1, 8'hB3, 0, 1, 1, 1, 3, 1, 32'hB0B1B2B3, 2'd0), "bp9");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0), "bp10");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0), "bp11");

    // Flush held while the output slot is busy
    apply(mk(0, 1, 8'hC0, 0, 0, 1, 0, 0, 0, 0, 0), "fs0");
    apply(mk(0, 1, 8'hC1, 0, 0, 1, 0, 1, 0, 0, 0), "fs1");
    apply(mk(0, 1, 8'hC2, 0, 0, 1, 0, 2, 0, 0, 0), "fs2");
    apply(mk(0, 1, 8'hC3, 0, 0, 1, 0, 3, 1, 32'hC0C1C2C3, 2'd0), "fs3");
    apply(mk(0, 1, 8'hD0, 0, 0, 1, 1, 0, 0, 0, 0), "fs4");
    apply(mk(0, 1, 8'hD1, 1, 0, 0, 1, 1, 0, 0, 0), "fs5");
    apply(mk(0, 1, 8'hD1, 1, 0, 0, 1, 1, 0, 0, 0), "fs6");
    check("fs_hold_data", out_data, 32'hC0C1C2C3);
    apply(mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 1, 32'hD0000000, 2'd1), "fs7");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0), "fs8");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0), "fs9");

    // Reset mid-word drops the partial bytes
    apply(mk(0, 1, 8'h11, 0, 1, 1, 0, 0, 0, 0, 0), "rm0");
    apply(mk(0, 1, 8'h22, 0, 1, 1, 0, 1, 0, 0, 0), "rm1");
    apply(mk(0, 1, 8'h33, 0, 1, 1, 0, 2, 0, 0, 0), "rm2");
    apply(mk(1, 1, 8'h99, 0, 1, 0, 0, 3, 0, 0, 0), "rm3");
    apply(mk(0, 1, 8'h44, 0, 1, 1, 0, 0, 0, 0, 0), "rm4");
    apply(mk(0, 1, 8'h45, 0, 1, 1, 0, 1, 0, 0, 0), "rm5");
    apply(mk(0, 1, 8'h46, 0, 1, 1, 0, 2, 0, 0, 0), "rm6");
    apply(mk(0, 1, 8'h47, 0, 1, 1, 0, 3, 1, 32'h44454647, 2'd0), "rm7");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0), "rm8");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0), "rm9");

    // Reset with a word pending drops the word
    apply(mk(0, 1, 8'hE0, 0, 0, 1, 0, 0, 0, 0, 0), "rp0");
    apply(mk(0, 1, 8'hE1, 0, 0, 1, 0, 1, 0, 0, 0), "rp1");
    apply(mk(0, 1, 8'hE2, 0, 0, 1, 0, 2, 0, 0, 0), "rp2");
    apply(mk(0, 1, 8'hE3, 0, 0, 1, 0, 3, 0, 0, 0), "rp3");
    apply(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0), "rp4");
    check("rp_out_data", out_data, 32'h0);
    check("rp_out_bytes", {30'd0, out_bytes}, 32'h0);
    apply(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0), "rp5");

`ifdef WORD_PACKER_COUNT_EN
    // 17 words through a 4-bit counter wraps to 1
    apply(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0), "wc_rst");
    check("wc_reset", {28'd0, word_count}, 32'h0);
    for (int k = 0; k < 17; k++) begin
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(0, 255));
      w = {b[0], b[1], b[2], b[3]};
      for (int j = 0; j < 4; j++)
        apply(mk(0, 1, b[j], 0, 1, 1, (k > 0 && j == 0), 2'(j), (j == 3), w, 2'd0),
              $sformatf("wc%0d_%0d", k, j));
    end
    apply(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0), "wc_end0");
    apply(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0), "wc_end1");
    check("wc_wrap", {28'd0, word_count}, 32'h1);
`endif

    check("queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
